// File: rtl/aclk_pkg.sv
// Alarm clock shared types: FSM state encoding and
// default ring/snooze timing.
package aclk_pkg;

  localparam int RING_MIN_DEF   = 5;
  localparam int SNOOZE_MIN_DEF = 9;
  localparam int MAX_SNOOZE_DEF = 3;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_RINGING  = 3'd2,
    ST_SNOOZE   = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/aclk_edge_det.sv
// Rising-edge detector: one registered clk pulse per
// low-to-high transition of a synchronous level.
module aclk_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic pulse_o
);

  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= sig_i;
      pulse_q <= sig_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/aclk_alarm_seq.sv
// Alarm sequencer: arms, rings on time match, snoozes
// a limited number of times and auto-stops.
module aclk_alarm_seq
  import aclk_pkg::*;
#(
  parameter int RING_MIN   = RING_MIN_DEF,
  parameter int SNOOZE_MIN = SNOOZE_MIN_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       one_minute,
  input  logic       alarm_enable,
  input  logic       snooze_button,
  input  logic       stop_button,
  input  logic [3:0] current_time_ms_hr,
  input  logic [3:0] current_time_ls_hr,
  input  logic [3:0] current_time_ms_min,
  input  logic [3:0] current_time_ls_min,
  input  logic [3:0] alarm_time_ms_hr,
  input  logic [3:0] alarm_time_ls_hr,
  input  logic [3:0] alarm_time_ms_min,
  input  logic [3:0] alarm_time_ls_min,
  output logic       sound_alarm,
  output logic       beep,
  output logic       snooze_active,
  output logic [3:0] snoozes_left,
  output logic [2:0] state
);

  localparam logic [3:0] RING_LIM = 4'(RING_MIN);
  localparam logic [3:0] SNZ_LIM  = 4'(SNOOZE_MIN);
  localparam logic [3:0] MAX_LIM  = 4'(MAX_SNOOZE);

  logic       snz_p;
  logic       stp_p;
  logic       match;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0] used_q, used_d;
  logic       beep_q, beep_d;
  logic       sound_q;
  logic       snzact_q;
  logic [3:0] left_q;

  aclk_edge_det u_snz_edge (
    .clk     (clk),
    .reset   (reset),
    .sig_i   (snooze_button),
    .pulse_o (snz_p)
  );

  aclk_edge_det u_stp_edge (
    .clk     (clk),
    .reset   (reset),
    .sig_i   (stop_button),
    .pulse_o (stp_p)
  );

  assign match =
    {current_time_ms_hr, current_time_ls_hr,
     current_time_ms_min, current_time_ls_min} ==
    {alarm_time_ms_hr, alarm_time_ls_hr,
     alarm_time_ms_min, alarm_time_ls_min};

  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    used_d  = used_q;
    beep_d  = 1'b0;
    if (!alarm_enable) begin
      state_d = ST_DISARMED;
      cnt_d   = 4'd0;
      used_d  = 4'd0;
    end else begin
      unique case (state_q)
        ST_DISARMED: state_d = ST_ARMED;
        ST_ARMED: begin
          if (match) begin
            state_d = ST_RINGING;
            cnt_d   = 4'd0;
            used_d  = 4'd0;
          end
        end
        ST_RINGING: begin
          if (stp_p) begin
            state_d = ST_DONE;
            cnt_d   = 4'd0;
          end else if (snz_p && used_q < MAX_LIM) begin
            state_d = ST_SNOOZE;
            used_d  = used_q + 4'd1;
            cnt_d   = 4'd0;
          end else if (one_minute) begin
            if (cnt_inc >= RING_LIM) begin
              state_d = ST_DONE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_SNOOZE: begin
          if (stp_p) begin
            state_d = ST_DONE;
            cnt_d   = 4'd0;
          end else if (one_minute) begin
            if (cnt_inc >= SNZ_LIM) begin
              state_d = ST_RINGING;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_DONE: begin
          // Wait for the matching minute to pass before re-arming
          if (!match) state_d = ST_ARMED;
        end
        default: state_d = ST_DISARMED;
      endcase
    end
    if (state_q == ST_RINGING && state_d == ST_RINGING)
      beep_d = beep_q ^ one_second;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_DISARMED;
      cnt_q    <= 4'd0;
      used_q   <= 4'd0;
      beep_q   <= 1'b0;
      sound_q  <= 1'b0;
      snzact_q <= 1'b0;
      left_q   <= MAX_LIM;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      used_q   <= used_d;
      beep_q   <= beep_d;
      sound_q  <= (state_d == ST_RINGING);
      snzact_q <= (state_d == ST_SNOOZE);
      left_q   <= MAX_LIM - used_d;
    end
  end

  assign sound_alarm   = sound_q;
  assign beep          = beep_q;
  assign snooze_active = snzact_q;
  assign snoozes_left  = left_q;
  assign state         = state_q;

endmodule

// File: tb/tb_aclk_alarm_seq.sv
// Self-checking bench for aclk_alarm_seq: vector table
// for the basic ring cycle plus snooze/stop/reset sequences.
module tb_aclk_alarm_seq;

  localparam logic [2:0] DIS  = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] RING = 3'd2;
  localparam logic [2:0] SNZ  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        sec, mn, en, snz, stp;
  logic [15:0] cur, alm;
  logic        sound, bp, sa;
  logic [3:0]  left;
  logic [2:0]  state;

  int total = 0;
  int pass  = 0;

  typedef struct {
    logic        en;
    logic        sec;
    logic        mn;
    logic [15:0] t;
    logic [2:0]  st;
    logic        snd;
    logic        bp;
    logic        sa;
    logic [3:0]  left;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       snd;
    logic       bp;
    logic       sa;
    logic [3:0] left;
  } exp_t;

  vec_t vecs[15];
  exp_t sbq[$];

  aclk_alarm_seq dut (
    .clk                 (clk),
    .reset               (reset),
    .one_second          (sec),
    .one_minute          (mn),
    .alarm_enable        (en),
    .snooze_button       (snz),
    .stop_button         (stp),
    .current_time_ms_hr  (cur[15:12]),
    .current_time_ls_hr  (cur[11:8]),
    .current_time_ms_min (cur[7:4]),
    .current_time_ls_min (cur[3:0]),
    .alarm_time_ms_hr    (alm[15:12]),
    .alarm_time_ls_hr    (alm[11:8]),
    .alarm_time_ms_min   (alm[7:4]),
    .alarm_time_ls_min   (alm[3:0]),
    .sound_alarm         (sound),
    .beep                (bp),
    .snooze_active       (sa),
    .snoozes_left        (left),
    .state               (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] got,
                     input logic [3:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  task automatic clk1(input logic [2:0] st, input logic snd,
                      input logic b, input logic s,
                      input logic [3:0] l, input string nm);
    exp_t e;
    e = '{st, snd, b, s, l};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({nm, ".state"}, state, e.st);
    chk({nm, ".sound"}, sound, e.snd);
    chk({nm, ".beep"}, bp, e.bp);
    chk({nm, ".snzact"}, sa, e.sa);
    chk({nm, ".left"}, left, e.left);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    //          en   sec  mn   time      st    snd  bp   sa   left
    vecs[0]  = '{1'b0,1'b0,1'b0,16'h0729,DIS, 1'b0,1'b0,1'b0,4'd3};
    vecs[1]  = '{1'b1,1'b0,1'b0,16'h0729,ARM, 1'b0,1'b0,1'b0,4'd3};
    vecs[2]  = '{1'b1,1'b0,1'b0,16'h0730,RING,1'b1,1'b0,1'b0,4'd3};
    vecs[3]  = '{1'b1,1'b1,1'b0,16'h0730,RING,1'b1,1'b1,1'b0,4'd3};
    vecs[4]  = '{1'b1,1'b1,1'b0,16'h0730,RING,1'b1,1'b0,1'b0,4'd3};
    vecs[5]  = '{1'b1,1'b0,1'b0,16'h0730,RING,1'b1,1'b0,1'b0,4'd3};
    vecs[6]  = '{1'b1,1'b1,1'b0,16'h0730,RING,1'b1,1'b1,1'b0,4'd3};
    vecs[7]  = '{1'b1,1'b0,1'b1,16'h0730,RING,1'b1,1'b1,1'b0,4'd3};
    vecs[8]  = '{1'b1,1'b0,1'b1,16'h0730,RING,1'b1,1'b1,1'b0,4'd3};
    vecs[9]  = '{1'b1,1'b0,1'b1,16'h0730,RING,1'b1,1'b1,1'b0,4'd3};
    vecs[10] = '{1'b1,1'b0,1'b1,16'h0730,RING,1'b1,1'b1,1'b0,4'd3};
    vecs[11] = '{1'b1,1'b0,1'b1,16'h0730,DONE,1'b0,1'b0,1'b0,4'd3};
    vecs[12] = '{1'b1,1'b0,1'b0,16'h0730,DONE,1'b0,1'b0,1'b0,4'd3};
    vecs[13] = '{1'b1,1'b0,1'b0,16'h0731,ARM, 1'b0,1'b0,1'b0,4'd3};
    vecs[14] = '{1'b1,1'b0,1'b0,16'h0731,ARM, 1'b0,1'b0,1'b0,4'd3};

    reset = 1'b1;
    sec = 0; mn = 0; en = 0; snz = 0; stp = 0;
    cur = 16'h0729;
    alm = 16'h0730;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.state", state, DIS);
    chk("rst.sound", sound, 1'b0);
    chk("rst.beep", bp, 1'b0);
    chk("rst.snzact", sa, 1'b0);
    chk("rst.left", left, 4'd3);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      en  = vecs[i].en;
      sec = vecs[i].sec;
      mn  = vecs[i].mn;
      cur = vecs[i].t;
      clk1(vecs[i].st, vecs[i].snd, vecs[i].bp, vecs[i].sa,
           vecs[i].left, $sformatf("v%0d", i));
    end
    sec = 0; mn = 0;

    // three honoured snoozes, each followed by a 9-minute re-ring
    cur = 16'h0730;
    clk1(RING, 1, 0, 0, 3, "ring2");
    for (int k = 0; k < 3; k++) begin
      snz = 1;
      clk1(RING, 1, 0, 0, 4'(3 - k), $sformatf("snzA%0d", k));
      snz = 0;
      clk1(SNZ, 0, 0, 1, 4'(2 - k), $sformatf("snzB%0d", k));
      for (int m = 0; m < 9; m++) begin
        mn = 1;
        clk1((m == 8) ? RING : SNZ, m == 8, 0, m != 8, 4'(2 - k),
             $sformatf("snz%0dm%0d", k, m));
      end
      mn = 0;
    end
    snz = 1;
    clk1(RING, 1, 0, 0, 0, "snz4a");
    snz = 0;
    clk1(RING, 1, 0, 0, 0, "snz4ign");
    for (int m = 0; m < 5; m++) begin
      mn = 1;
      clk1((m == 4) ? DONE : RING, m != 4, 0, 0, 0,
           $sformatf("auto%0d", m));
    end
    mn = 0;
    cur = 16'h0731;
    clk1(ARM, 0, 0, 0, 0, "rearm");

    // snooze and minute tick in the same cycle
    cur = 16'h0730;
    clk1(RING, 1, 0, 0, 3, "ring3");
    snz = 1;
    clk1(RING, 1, 0, 0, 3, "smA");
    snz = 0; mn = 1;
    clk1(SNZ, 0, 0, 1, 2, "smB");
    for (int m = 0; m < 9; m++) begin
      clk1((m == 8) ? RING : SNZ, m == 8, 0, m != 8, 2,
           $sformatf("sm_m%0d", m));
    end
    mn = 0;
    clk1(RING, 1, 0, 0, 2, "smhold");

    // stop wins over snooze; enable drop during snooze
    stp = 1; snz = 1;
    clk1(RING, 1, 0, 0, 2, "ssA");
    stp = 0; snz = 0;
    clk1(DONE, 0, 0, 0, 2, "ssB");
    cur = 16'h0731;
    clk1(ARM, 0, 0, 0, 2, "ssarm");
    cur = 16'h0730;
    clk1(RING, 1, 0, 0, 3, "ring4");
    snz = 1;
    clk1(RING, 1, 0, 0, 3, "dsA");
    snz = 0;
    clk1(SNZ, 0, 0, 1, 2, "dsB");
    en = 0;
    clk1(DIS, 0, 0, 0, 3, "dsoff");

    // asynchronous reset while ringing
    en = 1;
    clk1(ARM, 0, 0, 0, 3, "rA");
    clk1(RING, 1, 0, 0, 3, "rB");
    sec = 1;
    clk1(RING, 1, 1, 0, 3, "rC");
    sec = 0;
    reset = 1;
    #1;
    chk("arst.state", state, DIS);
    chk("arst.sound", sound, 1'b0);
    chk("arst.beep", bp, 1'b0);
    chk("arst.snzact", sa, 1'b0);
    chk("arst.left", left, 4'd3);
    en = 0;
    @(posedge clk);
    #1;
    reset = 0;
    clk1(DIS, 0, 0, 0, 3, "pr0");
    clk1(DIS, 0, 0, 0, 3, "pr1");
    en = 1;
    clk1(ARM, 0, 0, 0, 3, "pr2");
    clk1(RING, 1, 0, 0, 3, "pr3");

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
